reg_wb_ctrl: RTL and testbench



---
 rtl/reg_wb_ctrl.sv | 115 +++++++++++
 tb/tb_reg_wb_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_ctrl.sv
// Register-file writeback controller: arbitrates load-FIFO and ALU results onto a
// single registered write port and tracks per-register pending-write state.
module reg_wb_ctrl #(
  parameter int XLEN     = 32,
  parameter int LD_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  input  logic [1:0]      ld_offset,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            rf_w_en,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_rdv,
  output logic [31:0]     busy
);
  localparam int AW = $clog2(LD_DEPTH);
  localparam logic [AW:0] DEPTH_C = LD_DEPTH[AW:0];

  logic [4:0]      fifo_rd   [LD_DEPTH];
  logic [XLEN-1:0] fifo_data [LD_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic            empty, full, push, pop, sel_valid;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data, ld_fmt;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     busy_nxt;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  // Readies are gated by reset so nothing can look accepted while held in reset.
  assign ld_ready  = rst_n & ~full;
  assign alu_ready = rst_n & empty;
  assign push = ld_valid & ld_ready;
  assign pop  = ~empty;

  // FIFO head always wins; ALU only gets the port when the FIFO is empty.
  assign sel_valid = pop | alu_valid;
  assign sel_rd    = empty ? alu_rd   : fifo_rd[rd_ptr];
  assign sel_data  = empty ? alu_data : fifo_data[rd_ptr];

  assign ld_byte = ld_data[8*ld_offset +: 8];
  assign ld_half = ld_data[16*ld_offset[1] +: 16];

  always_comb begin
    ld_fmt = ld_data;
    case (ld_size)
      2'b00:   ld_fmt = {{(XLEN-8){~ld_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{(XLEN-16){~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_fmt = ld_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_fmt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set after clear so a same-cycle issue keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (sel_valid)   busy_nxt[sel_rd]   = 1'b0;
    if (issue_valid) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_w_en <= 1'b0;
      rf_rd   <= '0;
      rf_rdv  <= '0;
      busy    <= '0;
    end else begin
      busy <= busy_nxt;
      if (sel_valid && sel_rd != 5'd0) begin
        rf_w_en <= 1'b1;
        rf_rd   <= sel_rd;
        rf_rdv  <= sel_data;
      end else begin
        rf_w_en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Scoreboard bench for reg_wb_ctrl: a queue-based model predicts each register
// write and the busy vector; a negedge monitor compares against the DUT.
module tb_reg_wb_ctrl;
  localparam int XLEN = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_valid, alu_ready, ld_valid, ld_ready, ld_unsigned, issue_valid, rf_w_en;
  logic [4:0] alu_rd, ld_rd, issue_rd, rf_rd;
  logic [31:0] alu_data, ld_data, rf_rdv, busy;
  logic [1:0] ld_size, ld_offset;

  reg_wb_ctrl #(.XLEN(XLEN), .LD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned), .ld_offset(ld_offset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_w_en(rf_w_en), .rf_rd(rf_rd), .rf_rdv(rf_rdv), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] d; } wr_t;
  wr_t ld_q[$];
  wr_t exp_q[$];
  logic [31:0] busy_m = '0;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] d, input logic [1:0] sz,
                                      input logic uns, input logic [1:0] off);
    longint v;
    if (sz == 2'd0) begin
      v = (d >> (8 * off)) % 256;
      if (!uns && v > 127) v = v - 256;
    end else if (sz == 2'd1) begin
      v = (d >> (16 * (off / 2))) % 65536;
      if (!uns && v > 32767) v = v - 65536;
    end else v = d;
    return v[31:0];
  endfunction

  // Reference model: one write per cycle, FIFO contents first, then ALU.
  always @(posedge clk) if (rst_n) begin
    wr_t w;
    bit had;
    int pre;
    pre = ld_q.size();
    had = 1'b0;
    if (pre > 0) begin w = ld_q.pop_front(); had = 1'b1; end
    else if (alu_valid) begin w.rd = alu_rd; w.d = alu_data; had = 1'b1; end
    if (ld_valid && pre < DEPTH) begin
      wr_t l;
      l.rd = ld_rd;
      l.d = fmt(ld_data, ld_size, ld_unsigned, ld_offset);
      ld_q.push_back(l);
    end
    if (had) busy_m[w.rd] = 1'b0;
    if (issue_valid) busy_m[issue_rd] = 1'b1;
    busy_m[0] = 1'b0;
    if (had && w.rd != 0) exp_q.push_back(w);
  end

  always @(negedge rst_n) begin
    ld_q.delete();
    exp_q.delete();
    busy_m = '0;
  end

  // Monitor
  always @(negedge clk) if (rst_n) begin
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, ld_q.size() == 0});
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, ld_q.size() < DEPTH});
    chk("busy", busy, busy_m);
    if (exp_q.size() > 0) begin
      wr_t e;
      e = exp_q.pop_front();
      chk("w_en", {31'd0, rf_w_en}, 32'd1);
      chk("rf_rd", {27'd0, rf_rd}, {27'd0, e.rd});
      chk("rf_rdv", rf_rdv, e.d);
    end else chk("w_en_idle", {31'd0, rf_w_en}, 32'd0);
  end

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; ld_size = 0; ld_unsigned = 0; ld_offset = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic load_chk(input string name, input logic [4:0] rd, input logic [31:0] d,
                          input logic [1:0] sz, input logic uns, input logic [1:0] off,
                          input logic [31:0] exp);
    idle();
    ld_valid = 1; ld_rd = rd; ld_data = d; ld_size = sz; ld_unsigned = uns; ld_offset = off;
    @(negedge clk); idle();
    @(negedge clk);
    chk({name, "_en"}, {31'd0, rf_w_en}, 32'd1);
    chk(name, rf_rdv, exp);
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    #1;
    chk("rst_w_en", {31'd0, rf_w_en}, 32'd0);
    chk("rst_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_rdv", rf_rdv, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    @(negedge clk);

    // ALU single write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    @(negedge clk); idle();
    chk("alu_en", {31'd0, rf_w_en}, 32'd1);
    chk("alu_rd", {27'd0, rf_rd}, 32'd5);
    chk("alu_rdv", rf_rdv, 32'hDEADBEEF);
    @(negedge clk);
    chk("alu_en_drop", {31'd0, rf_w_en}, 32'd0);

    // Load formatting
    load_chk("lb_s", 7, 32'h0000_8000, 2'd0, 0, 2'd1, 32'hFFFFFF80);
    load_chk("lb_u", 7, 32'h0000_8000, 2'd0, 1, 2'd1, 32'h00000080);
    load_chk("lh_s", 7, 32'h8001_0000, 2'd1, 0, 2'd2, 32'hFFFF8001);
    load_chk("lh_odd", 8, 32'h1234_ABCD, 2'd1, 1, 2'd1, 32'h0000ABCD);
    load_chk("lw_off", 8, 32'hCAFE_F00D, 2'd3, 0, 2'd3, 32'hCAFEF00D);

    // Same-cycle ALU and load with FIFO empty
    ld_valid = 1; ld_rd = 3; ld_data = 32'h11; ld_size = 2'd2;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h22;
    @(negedge clk); idle();
    chk("both_rd1", {27'd0, rf_rd}, 32'd4);
    chk("both_rdv1", rf_rdv, 32'h22);
    chk("both_alu_ready", {31'd0, alu_ready}, 32'd0);
    @(negedge clk);
    chk("both_rd2", {27'd0, rf_rd}, 32'd3);
    chk("both_rdv2", rf_rdv, 32'h11);
    @(negedge clk);

    // Back-to-back loads with ALU held (scoreboard checks order/backpressure)
    ld_valid = 1; ld_size = 2'd2; alu_valid = 1; alu_rd = 20; alu_data = 32'hA1;
    for (int i = 0; i < 4; i++) begin
      ld_rd = 5'(10 + i); ld_data = 32'h100 + i;
      @(negedge clk);
    end
    idle();
    repeat (4) @(negedge clk);

    // rd==0 consumed without a write
    alu_valid = 1; alu_rd = 0; alu_data = 32'h5;
    #1 chk("rd0_ready", {31'd0, alu_ready}, 32'd1);
    @(negedge clk); idle();
    chk("rd0_no_write", {31'd0, rf_w_en}, 32'd0);

    // Scoreboard set/clear collision
    issue_valid = 1; issue_rd = 9;
    @(negedge clk); idle();
    chk("busy9_set", {31'd0, busy[9]}, 32'd1);
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99; issue_valid = 1; issue_rd = 9;
    @(negedge clk); idle();
    chk("busy9_hold", {31'd0, busy[9]}, 32'd1);
    alu_valid = 1; alu_rd = 9; alu_data = 32'h98;
    @(negedge clk); idle();
    chk("busy9_clear", {31'd0, busy[9]}, 32'd0);

    // Randomized traffic with a reset in the middle
    for (int c = 0; c < 3000; c++) begin
      alu_valid = ($urandom_range(0, 1) == 1);
      alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_rd = 5'($urandom_range(0, 31)); ld_data = $urandom;
      ld_size = 2'($urandom_range(0, 3)); ld_unsigned = 1'($urandom_range(0, 1));
      ld_offset = 2'($urandom_range(0, 3));
      issue_valid = ($urandom_range(0, 2) == 0); issue_rd = 5'($urandom_range(0, 31));
      if (c == 1500) begin
        issue_valid = 1; issue_rd = 17; ld_valid = 1;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_w_en", {31'd0, rf_w_en}, 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_rd", {27'd0, rf_rd}, 32'd0);
        idle();
        @(negedge clk);
        #2 rst_n = 1;
        #1;
        chk("mid_rst_empty", {31'd0, alu_ready}, 32'd1);
        chk("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
      end
      @(negedge clk);
    end
    idle();
    repeat (6) @(negedge clk);
    chk("drained_exp", exp_q.size(), 32'd0);
    chk("drained_fifo", ld_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
